nios2_pio_gpio: RTL and testbench
=================================

Name: nios2_pio_gpio

Overview:
- Parametrised general-purpose I/O peripheral on the Nios II Avalon-MM fabric, succeeding the single-bit output-only control PIOs.
- Provides WIDTH bidirectional pins with a per-bit direction register and atomic set/clear output writes.
- Inputs pass through a synchroniser into edge capture with a maskable interrupt.
- Used for AGC board controls, status lines and button/flag inputs.

Parameters:
- WIDTH, 8: number of I/O bits, legal 1..32.
- SYNC_STAGES, 2: input synchroniser depth, legal 2..4.
- EDGE_TYPE, 0: capture edge; 0 rising, 1 falling, 2 any.
- IRQ_TYPE, 1: interrupt source; 0 level, 1 edge.
- OUT_RESET, 0: reset value of the output data register (WIDTH bits).
- DIR_RESET, 0: reset value of the direction register; bit = 1 means output.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- address  input  3  word address
- chipselect  input  1  slave select
- read_n  input  1  active-low read strobe
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  read data, registered
- in_port  input  WIDTH  asynchronous pin inputs
- out_port  output  WIDTH  output data register
- out_en  output  WIDTH  per-bit output enable (= direction register)
- irq  output  1  interrupt request, registered

Behaviour:
- Reset: data_out = OUT_RESET, dir = DIR_RESET, irqmask = 0, edgecapture = 0, sync/delay regs = 0, readdata = 0, irq = 0, arm counter = 0.
- Register map, word address:
  - 0 DATA: read returns per bit (dir ? data_out : sync_in); write loads data_out.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read; write 1 clears the bit.
  - 4 OUTSET: write data_out |= wd; reads 0.
  - 5 OUTCLR: write data_out &= ~wd; reads 0.
  - 6, 7: reserved; reads 0, writes ignored.
- Write strobe = chipselect & ~write_n. The register updates at the clock edge of the strobe cycle.
- Only writedata[WIDTH-1:0] is used. readdata bits [31:WIDTH] are always 0.
- Read: when chipselect & ~read_n, readdata is loaded with the mux value at the next edge (read latency 1). Otherwise readdata is loaded with 0.
- Synchroniser: SYNC_STAGES flops per bit; sync_in is the last stage. A delay register holds the previous sync_in.
- Edge detection:
  - rise = sync_in & ~delay; fall = ~sync_in & delay.
  - Selected by EDGE_TYPE, gated by the arm flag.
- Arm counter: counts 0..SYNC_STAGES+1 after reset, then saturates. While the count is below SYNC_STAGES+1, arm = 0 and no edges are captured. This suppresses false edges from the reset state.
- edgecapture bit: set on a detected edge, cleared by a 1 written to EDGECAP, sticky otherwise. If set and clear land on the same bit in the same cycle, set wins.
- Edges are captured on all bits regardless of direction. In level mode, input-direction bits only contribute to irq.
- irq, registered one cycle:
  - IRQ_TYPE 1: irq <= |(edgecapture & irqmask).
  - IRQ_TYPE 0: irq <= |(sync_in & ~dir & irqmask).
- Latency, with in_port stable before clock edge 0:
  - sync_in valid at edge SYNC_STAGES-1.
  - edgecapture set at edge SYNC_STAGES.
  - irq (edge mode) at edge SYNC_STAGES+1.
- Pulses on in_port shorter than one clock period may be missed. This is acceptable and not flagged.
- Writes to a read-only offset, and reads of write-only offsets, have no side effects. Reading EDGECAP does not clear it.
- Reset asserted mid-operation: all state returns asynchronously to reset values, and the arm counter restarts.

Test Plan:
- Reset with OUT_RESET=8'hA5, DIR_RESET=8'h0F, then read addr 0 and addr 1 → out_port=8'hA5, out_en=8'h0F; readdata=32'h0000000F one cycle after the addr 1 read; irq=0.
- Write DATA=8'h3C, then OUTSET=8'h81, then OUTCLR=8'h0C → out_port 8'h3C → 8'hBD → 8'hB1. Read addr 4 → 0.
- DIR=8'hF0, data_out=8'hA0, in_port=8'h05, read DATA after ≥3 cycles → readdata=32'h000000A5.
- EDGE_TYPE=0, IRQ_TYPE=1, IRQMASK=8'h02, in_port[1] 0→1 → EDGECAP=8'h02 at edge 2 and irq=1 at edge 3. Write EDGECAP=8'h02 → EDGECAP=0 and irq=0 next cycle.
- Rising edge on bit 0 detected in the same cycle as a write EDGECAP=8'h01 → bit 0 stays 1.
- in_port=8'hFF held through reset release → EDGECAP stays 0 (arm suppression). IRQ_TYPE=0, IRQMASK=8'h01, DIR=0 → irq=1 with a 1-cycle register delay. Assert reset_n=0 mid-sequence → irq=0, out_port=OUT_RESET immediately.

Source files
------------

// File: rtl/nios2_pio_gpio_if.sv
// ============================================================================
// Module   : nios2_pio_gpio_if
// Brief    : Avalon-MM slave bus bundle for the GPIO PIO peripheral.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nios2_pio_gpio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

`default_nettype wire

// File: rtl/nios2_pio_gpio.sv
// ============================================================================
// Module   : nios2_pio_gpio
// Brief    : WIDTH-bit bidirectional GPIO with set/clear writes, synchronised
//            inputs, edge capture and a maskable level/edge interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios2_pio_gpio #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter int               IRQ_TYPE    = 1,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  nios2_pio_gpio_if.slave       bus,
  input  wire logic [WIDTH-1:0] in_port,
  output logic      [WIDTH-1:0] out_port,
  output logic      [WIDTH-1:0] out_en,
  output logic                  irq
);

  localparam logic [2:0] c_ADDR_DATA    = 3'd0;
  localparam logic [2:0] c_ADDR_DIR     = 3'd1;
  localparam logic [2:0] c_ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] c_ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] c_ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] c_ADDR_OUTCLR  = 3'd5;

  localparam int                c_ARM_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [c_ARM_W-1:0] c_ARM_MAX = c_ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]   r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]   r_delay;
  logic [WIDTH-1:0]   r_data_out;
  logic [WIDTH-1:0]   r_dir;
  logic [WIDTH-1:0]   r_irqmask;
  logic [WIDTH-1:0]   r_edgecap;
  logic [31:0]        r_readdata;
  logic               r_irq;
  logic [c_ARM_W-1:0] r_arm_cnt;

  logic               w_wr;
  logic               w_rd;
  logic [WIDTH-1:0]   w_wd;
  logic [WIDTH-1:0]   w_sync_in;
  logic               w_arm;
  logic [WIDTH-1:0]   w_edge_raw;
  logic [WIDTH-1:0]   w_edge;
  logic [WIDTH-1:0]   w_ecap_clr;
  logic               w_irq_next;
  logic [31:0]        w_rd_mux;

  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_rd      = bus.chipselect & ~bus.read_n;
  assign w_wd      = bus.writedata[WIDTH-1:0];
  assign w_sync_in = r_sync[SYNC_STAGES-1];

  generate
    if (WIDTH < 32) begin : g_unused_wd
      wire w_unused_wd = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  // Input synchroniser plus one-cycle history for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_delay <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_delay <= w_sync_in;
    end
  end

  // Edges are ignored until the chain has flushed its reset zeros
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_arm_cnt <= '0;
    else if (r_arm_cnt != c_ARM_MAX)
      r_arm_cnt <= r_arm_cnt + 1'b1;
  end

  assign w_arm = (r_arm_cnt == c_ARM_MAX);

  generate
    if (EDGE_TYPE == 0) begin : g_edge_rise
      assign w_edge_raw = w_sync_in & ~r_delay;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign w_edge_raw = ~w_sync_in & r_delay;
    end else begin : g_edge_any
      assign w_edge_raw = w_sync_in ^ r_delay;
    end
  endgenerate

  assign w_edge     = w_arm ? w_edge_raw : '0;
  assign w_ecap_clr = (w_wr && bus.address == c_ADDR_EDGECAP) ? w_wd : '0;

  generate
    if (IRQ_TYPE == 1) begin : g_irq_edge
      assign w_irq_next = |(r_edgecap & r_irqmask);
    end else begin : g_irq_level
      assign w_irq_next = |(w_sync_in & ~r_dir & r_irqmask);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= OUT_RESET;
      r_dir      <= DIR_RESET;
      r_irqmask  <= '0;
      r_edgecap  <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr) begin
        case (bus.address)
          c_ADDR_DATA:    r_data_out <= w_wd;
          c_ADDR_DIR:     r_dir      <= w_wd;
          c_ADDR_IRQMASK: r_irqmask  <= w_wd;
          c_ADDR_OUTSET:  r_data_out <= r_data_out | w_wd;
          c_ADDR_OUTCLR:  r_data_out <= r_data_out & ~w_wd;
          default: ;
        endcase
      end
      // A fresh edge outranks a simultaneous clear on the same bit
      r_edgecap <= (r_edgecap & ~w_ecap_clr) | w_edge;
      r_irq     <= w_irq_next;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      c_ADDR_DATA:    w_rd_mux[WIDTH-1:0] = (r_dir & r_data_out) | (~r_dir & w_sync_in);
      c_ADDR_DIR:     w_rd_mux[WIDTH-1:0] = r_dir;
      c_ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
      c_ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_edgecap;
      default:        w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_readdata <= '0;
    else
      r_readdata <= w_rd ? w_rd_mux : 32'h0;
  end

  assign bus.readdata = r_readdata;
  assign out_port     = r_data_out;
  assign out_en       = r_dir;
  assign irq          = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_nios2_pio_gpio.sv
// ============================================================================
// Module   : tb_nios2_pio_gpio
// Brief    : Two GPIO instances (edge/rising and level/any-edge) sharing one
//            bus stimulus, checked against an input-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nios2_pio_gpio;
  localparam int W = 8;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   addr    = '0;
  logic         cs      = 1'b0;
  logic         rd_n    = 1'b1;
  logic         wr_n    = 1'b1;
  logic [31:0]  wd      = '0;
  logic [W-1:0] in_port = '0;

  logic [W-1:0] out_port_e, out_en_e, out_port_l, out_en_l;
  logic         irq_e, irq_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios2_pio_gpio_if bus_e ();
  nios2_pio_gpio_if bus_l ();

  assign bus_e.address = addr;  assign bus_l.address = addr;
  assign bus_e.chipselect = cs; assign bus_l.chipselect = cs;
  assign bus_e.read_n = rd_n;   assign bus_l.read_n = rd_n;
  assign bus_e.write_n = wr_n;  assign bus_l.write_n = wr_n;
  assign bus_e.writedata = wd;  assign bus_l.writedata = wd;

  nios2_pio_gpio #(
    .WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1),
    .OUT_RESET(8'hA5), .DIR_RESET(8'h0F)
  ) dut_e (
    .clk(clk), .reset_n(reset_n), .bus(bus_e), .in_port(in_port),
    .out_port(out_port_e), .out_en(out_en_e), .irq(irq_e)
  );

  nios2_pio_gpio #(
    .WIDTH(W), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_TYPE(0),
    .OUT_RESET(8'h5A), .DIR_RESET(8'h00)
  ) dut_l (
    .clk(clk), .reset_n(reset_n), .bus(bus_l), .in_port(in_port),
    .out_port(out_port_l), .out_en(out_en_l), .irq(irq_l)
  );

  // Reference model: index 0 mirrors dut_e's parameters, index 1 dut_l's
  int           c_sync [2] = '{2, 3};
  int           c_edge [2] = '{0, 2};
  int           c_irqt [2] = '{1, 0};
  logic [W-1:0] c_outr [2] = '{8'hA5, 8'h5A};
  logic [W-1:0] c_dirr [2] = '{8'h0F, 8'h00};

  logic [W-1:0] m_dout [2];
  logic [W-1:0] m_dir  [2];
  logic [W-1:0] m_mask [2];
  logic [W-1:0] m_ecap [2];
  logic         m_irq  [2];
  logic [31:0]  m_rd   [2];
  logic [W-1:0] hist [$];   // in_port value seen at each clock edge since reset

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_dout[c] = c_outr[c];
      m_dir[c]  = c_dirr[c];
      m_mask[c] = '0;
      m_ecap[c] = '0;
      m_irq[c]  = 1'b0;
      m_rd[c]   = '0;
    end
    hist.delete();
  endtask

  // Synchronised input after n edges: the pin value from s edges earlier
  function automatic logic [W-1:0] sync_after(input int s, input int n);
    if (n >= s) return hist[n-s];
    return '0;
  endfunction

  task automatic model_edge();
    int           n;
    bit           wr;
    bit           rd;
    logic [W-1:0] w;
    n  = hist.size();
    wr = cs && !wr_n;
    rd = cs && !rd_n;
    w  = wd[W-1:0];
    for (int c = 0; c < 2; c++) begin
      logic [W-1:0] sy, dl, ev, mux, clr;
      sy = sync_after(c_sync[c], n);
      dl = sync_after(c_sync[c], n - 1);
      if (c_edge[c] == 0)      ev = sy & ~dl;
      else if (c_edge[c] == 1) ev = ~sy & dl;
      else                     ev = (sy & ~dl) | (~sy & dl);
      if (n < c_sync[c] + 1) ev = '0;
      case (addr)
        3'd0:    mux = (m_dir[c] & m_dout[c]) | (~m_dir[c] & sy);
        3'd1:    mux = m_dir[c];
        3'd2:    mux = m_mask[c];
        3'd3:    mux = m_ecap[c];
        default: mux = '0;
      endcase
      m_rd[c]  = rd ? {24'h0, mux} : 32'h0;
      m_irq[c] = (c_irqt[c] == 1) ? |(m_ecap[c] & m_mask[c])
                                  : |(sy & ~m_dir[c] & m_mask[c]);
      clr = (wr && addr == 3'd3) ? w : '0;
      m_ecap[c] = (m_ecap[c] & ~clr) | ev;
      if (wr) begin
        case (addr)
          3'd0: m_dout[c] = w;
          3'd1: m_dir[c]  = w;
          3'd2: m_mask[c] = w;
          3'd4: m_dout[c] = m_dout[c] | w;
          3'd5: m_dout[c] = m_dout[c] & ~w;
          default: ;
        endcase
      end
    end
    hist.push_back(in_port);
  endtask

  task automatic compare_all();
    check("out_port_e", 32'(out_port_e), 32'(m_dout[0]));
    check("out_en_e",   32'(out_en_e),   32'(m_dir[0]));
    check("irq_e",      32'(irq_e),      32'(m_irq[0]));
    check("readdata_e", bus_e.readdata,  m_rd[0]);
    check("out_port_l", 32'(out_port_l), 32'(m_dout[1]));
    check("out_en_l",   32'(out_en_l),   32'(m_dir[1]));
    check("irq_l",      32'(irq_l),      32'(m_irq[1]));
    check("readdata_l", bus_l.readdata,  m_rd[1]);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic bus_idle();
    cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; wd = d; cs = 1'b1; wr_n = 1'b0; rd_n = 1'b1;
    step();
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] a);
    addr = a; cs = 1'b1; rd_n = 1'b0; wr_n = 1'b1;
    step();
    bus_idle();
  endtask

  // Reset asserted between edges must act immediately
  task automatic mid_reset();
    #3;
    reset_n = 1'b0;
    #1;
    check("async_irq_l", 32'(irq_l), 32'h0);
    check("async_out_e", 32'(out_port_e), 32'hA5);
    check("async_out_l", 32'(out_port_l), 32'h5A);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst_out_e", 32'(out_port_e), 32'hA5);
    check("rst_en_e",  32'(out_en_e),   32'h0F);
    check("rst_irq_e", 32'(irq_e),      32'h0);

    bus_read(3'd0);
    bus_read(3'd1);
    check("rd_dir_e", bus_e.readdata, 32'h0000000F);

    bus_write(3'd0, 32'h3C); check("data_wr", 32'(out_port_e), 32'h3C);
    bus_write(3'd4, 32'h81); check("outset",  32'(out_port_e), 32'hBD);
    bus_write(3'd5, 32'h0C); check("outclr",  32'(out_port_e), 32'hB1);
    bus_read(3'd4);          check("rd_outset", bus_e.readdata, 32'h0);

    bus_write(3'd1, 32'hF0);
    bus_write(3'd0, 32'hA0);
    in_port = 8'h05;
    repeat (3) step();
    bus_read(3'd0);
    check("rd_mixed", bus_e.readdata, 32'h000000A5);

    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h02);
    in_port = 8'h07;
    repeat (3) step();
    check("irq_not_yet", 32'(irq_e), 32'h0);
    step();
    check("irq_edge", 32'(irq_e), 32'h1);
    bus_read(3'd3);
    check("rd_ecap", bus_e.readdata, 32'h02);
    bus_write(3'd3, 32'h02);
    step();
    check("irq_cleared", 32'(irq_e), 32'h0);

    in_port = 8'h06;
    repeat (4) step();
    in_port = 8'h07;
    step();
    step();
    bus_write(3'd3, 32'h01);
    bus_read(3'd3);
    check("set_wins", bus_e.readdata, 32'h01);

    in_port = 8'hFF;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) step();
    bus_read(3'd3);
    check("arm_ecap_e", bus_e.readdata, 32'h0);
    check("arm_ecap_l", bus_l.readdata, 32'h0);
    bus_write(3'd1, 32'h00);
    bus_write(3'd2, 32'h01);
    check("lvl_irq_delay", 32'(irq_l), 32'h0);
    step();
    check("lvl_irq", 32'(irq_l), 32'h1);
    mid_reset();

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        bus_idle();
        mid_reset();
      end else begin
        cs   = ($urandom_range(0, 3) != 0);
        rd_n = $urandom_range(0, 1) == 1;
        wr_n = $urandom_range(0, 1) == 1;
        addr = 3'($urandom_range(0, 7));
        wd   = $urandom;
        if ($urandom_range(0, 2) == 0) in_port = in_port ^ W'($urandom & $urandom);
        step();
      end
    end
    bus_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
